// File: rtl/scratch_pad_port_arbiter_pkg.sv
// Shared definitions for the scratch_pad port arbiter: default sizing and the
// classification of a granted request.
package scratch_pad_port_arbiter_pkg;

  localparam int DefaultClients        = 4;
  localparam int DefaultWidth          = 64;
  localparam int DefaultAddrWidth      = 12;
  localparam int DefaultMaxOutstanding = 32;

  typedef enum logic [1:0] {
    REQ_NONE  = 2'd0,
    REQ_READ  = 2'd1,
    REQ_WRITE = 2'd2
  } req_kind_e;

endpackage

// File: rtl/scratch_pad_arb_id_fifo.sv
// Show-ahead FIFO of client IDs for reads in flight at the scratch_pad port.
// Head is valid whenever the FIFO is non-empty; a push and a pop may share a cycle.
module scratch_pad_arb_id_fifo #(
  parameter int DATA_BITS  = 2,
  parameter int DEPTH      = 32,
  localparam int PTR_BITS   = $clog2(DEPTH),
  localparam int COUNT_BITS = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_BITS-1:0]  data_i,
  output logic [DATA_BITS-1:0]  head_o,
  output logic [COUNT_BITS-1:0] count_o,
  output logic                  empty_o
);

  logic [DATA_BITS-1:0]  mem_q [DEPTH];
  logic [PTR_BITS-1:0]   wrPtr_q, wrPtr_d;
  logic [PTR_BITS-1:0]   rdPtr_q, rdPtr_d;
  logic [COUNT_BITS-1:0] count_q, count_d;
  logic                  pushOk;
  logic                  popOk;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  always_comb begin
    popOk   = pop_i && (count_q != '0);
    pushOk  = push_i && ((count_q < COUNT_BITS'(DEPTH)) || popOk);
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (pushOk) begin
      wrPtr_d = (wrPtr_q == PTR_BITS'(DEPTH - 1)) ? '0 : wrPtr_q + PTR_BITS'(1);
    end
    if (popOk) begin
      rdPtr_d = (rdPtr_q == PTR_BITS'(DEPTH - 1)) ? '0 : rdPtr_q + PTR_BITS'(1);
    end
    if (pushOk && !popOk) begin
      count_d = count_q + COUNT_BITS'(1);
    end else if (popOk && !pushOk) begin
      count_d = count_q - COUNT_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pushOk) begin
      mem_q[wrPtr_q] <= data_i;
    end
  end

  assign head_o  = mem_q[rdPtr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/scratch_pad_port_arbiter.sv
// Round-robin sharing of one scratch_pad port among several clients, with read
// responses steered back to their issuing client via an in-order ID FIFO.
module scratch_pad_port_arbiter
  import scratch_pad_port_arbiter_pkg::*;
#(
  parameter int CLIENTS         = DefaultClients,
  parameter int WIDTH           = DefaultWidth,
  parameter int ADDR_WIDTH      = DefaultAddrWidth,
  parameter int MAX_OUTSTANDING = DefaultMaxOutstanding,
  localparam int CLIENT_BITS    = $clog2(CLIENTS),
  localparam int COUNT_BITS     = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [0:CLIENTS-1]            c_rd_en,
  input  logic [0:CLIENTS-1]            c_wr_en,
  input  logic [ADDR_WIDTH*CLIENTS-1:0] c_addr,
  input  logic [WIDTH*CLIENTS-1:0]      c_d,
  output logic [0:CLIENTS-1]            c_grant,
  input  logic [0:CLIENTS-1]            c_stall,
  output logic [0:CLIENTS-1]            c_valid,
  output logic [WIDTH-1:0]              c_q,
  output logic                          sp_rd_en,
  output logic                          sp_wr_en,
  output logic [ADDR_WIDTH-1:0]         sp_addr,
  output logic [WIDTH-1:0]              sp_d,
  input  logic                          sp_full,
  input  logic [WIDTH-1:0]              sp_q,
  input  logic                          sp_valid,
  output logic                          sp_stall
);

  logic [CLIENT_BITS-1:0] ptr_q, ptr_d;
  logic                   sp_rd_en_q, sp_rd_en_d;
  logic                   sp_wr_en_q, sp_wr_en_d;
  logic [ADDR_WIDTH-1:0]  sp_addr_q, sp_addr_d;
  logic [WIDTH-1:0]       sp_d_q, sp_d_d;

  logic [COUNT_BITS-1:0]  fifoCount;
  logic [CLIENT_BITS-1:0] headId;
  logic                   fifoEmpty;
  logic                   fifoPush;
  logic                   fifoPop;
  logic                   readOk;
  logic [0:CLIENTS-1]     eligible;
  logic [CLIENT_BITS-1:0] scanId;
  logic [CLIENT_BITS-1:0] grantId;
  logic                   grantValid;
  req_kind_e              grantKind;

  // Response side: the head of the ID FIFO owns whatever the scratch_pad returns.
  always_comb begin
    c_valid  = '0;
    sp_stall = !rst && !fifoEmpty && c_stall[headId];
    fifoPop  = !rst && sp_valid && !fifoEmpty && !c_stall[headId];
    if (!rst && sp_valid && !fifoEmpty) begin
      c_valid[headId] = 1'b1;
    end
  end

  assign c_q = sp_q;

  // A response leaving this cycle frees the slot a new read would take.
  always_comb begin
    readOk = (fifoCount < COUNT_BITS'(MAX_OUTSTANDING)) || fifoPop;
    for (int i = 0; i < CLIENTS; i++) begin
      eligible[i] = !rst && !sp_full && (c_wr_en[i] || (c_rd_en[i] && readOk));
    end
  end

  always_comb begin
    grantValid = 1'b0;
    grantId    = ptr_q;
    scanId     = ptr_q;
    c_grant    = '0;
    for (int k = 0; k < CLIENTS; k++) begin
      scanId = ptr_q + CLIENT_BITS'(k);
      if (!grantValid && eligible[scanId]) begin
        grantValid = 1'b1;
        grantId    = scanId;
      end
    end
    if (grantValid) begin
      c_grant[grantId] = 1'b1;
    end
    if (!grantValid) begin
      grantKind = REQ_NONE;
    end else if (c_wr_en[grantId]) begin
      grantKind = REQ_WRITE;
    end else begin
      grantKind = REQ_READ;
    end
  end

  assign fifoPush = (grantKind == REQ_READ);

  always_comb begin
    ptr_d      = grantValid ? grantId + CLIENT_BITS'(1) : ptr_q;
    sp_rd_en_d = (grantKind == REQ_READ);
    sp_wr_en_d = (grantKind == REQ_WRITE);
    sp_addr_d  = sp_addr_q;
    sp_d_d     = sp_d_q;
    if (grantValid) begin
      sp_addr_d = c_addr[(CLIENTS - 1 - int'(grantId)) * ADDR_WIDTH +: ADDR_WIDTH];
      sp_d_d    = c_d[(CLIENTS - 1 - int'(grantId)) * WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      sp_rd_en_q <= 1'b0;
      sp_wr_en_q <= 1'b0;
      sp_addr_q  <= '0;
      sp_d_q     <= '0;
    end else begin
      ptr_q      <= ptr_d;
      sp_rd_en_q <= sp_rd_en_d;
      sp_wr_en_q <= sp_wr_en_d;
      sp_addr_q  <= sp_addr_d;
      sp_d_q     <= sp_d_d;
    end
  end

  assign sp_rd_en = sp_rd_en_q;
  assign sp_wr_en = sp_wr_en_q;
  assign sp_addr  = sp_addr_q;
  assign sp_d     = sp_d_q;

  scratch_pad_arb_id_fifo #(
    .DATA_BITS(CLIENT_BITS),
    .DEPTH    (MAX_OUTSTANDING)
  ) u_idFifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (fifoPush),
    .pop_i  (fifoPop),
    .data_i (grantId),
    .head_o (headId),
    .count_o(fifoCount),
    .empty_o(fifoEmpty)
  );

endmodule
